// File: rtl/sweep_pkg.sv
// rtl/sweep_pkg.sv - shared widths and state encoding for the sweep sequencer
package sweep_pkg;

    localparam int CNT_W   = 8;
    localparam int DWELL_W = 8;
    localparam int REP_W   = 4;

    // Values double as the externally visible phase encoding.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RAMP_UP  = 3'd1,
        ST_DWELL_HI = 3'd2,
        ST_RAMP_DN  = 3'd3,
        ST_DWELL_LO = 3'd4,
        ST_DONE     = 3'd5
    } sweep_state_t;

endpackage

// File: rtl/updn_counter.sv
// rtl/updn_counter.sv - up/down counter with clear (ena low) and hold
module updn_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         ena,
    input  logic         up_down,
    input  logic         hold,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else if (!ena) begin
            cnt_q <= '0;
        end else if (!hold) begin
            cnt_q <= up_down ? cnt_q + 1'b1 : cnt_q - 1'b1;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/sweep_ctrl.sv
// rtl/sweep_ctrl.sv - triangular sweep sequencer driving an up/down counter
module sweep_ctrl
    import sweep_pkg::*;
#(
    parameter int CNT_W   = sweep_pkg::CNT_W,
    parameter int DWELL_W = sweep_pkg::DWELL_W,
    parameter int REP_W   = sweep_pkg::REP_W
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               start,
    input  logic               abort,
    input  logic [CNT_W-1:0]   cfg_lo,
    input  logic [CNT_W-1:0]   cfg_hi,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic [REP_W-1:0]   cfg_reps,
    output logic [CNT_W-1:0]   cnt,
    output logic               busy,
    output logic [2:0]         phase,
    output logic [REP_W-1:0]   rep_idx,
    output logic               done,
    output logic               cfg_err
);

    sweep_state_t       state_q, state_d;
    logic [CNT_W-1:0]   lo_q, hi_q;
    logic [DWELL_W-1:0] dwell_q, timer_q, timer_d;
    logic [REP_W-1:0]   reps_q, rep_q, rep_d, rep_next;
    logic               err_q, err_d;
    logic               load_cfg, end_rep;
    logic               ena, up_down, hold;
    logic               at_hi, at_lo;

    assign at_hi    = (cnt == hi_q);
    assign at_lo    = (cnt == lo_q);
    assign rep_next = rep_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        rep_d    = rep_q;
        err_d    = 1'b0;
        load_cfg = 1'b0;
        end_rep  = 1'b0;
        ena      = 1'b0;
        up_down  = 1'b0;
        hold     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    if ((cfg_lo > cfg_hi) || (cfg_reps == '0)) begin
                        err_d = 1'b1;
                    end else begin
                        load_cfg = 1'b1;
                        rep_d    = '0;
                        state_d  = ST_RAMP_UP;
                    end
                end
            end
            ST_RAMP_UP: begin
                ena     = 1'b1;
                up_down = 1'b1;
                hold    = at_hi;
                if (at_hi) begin
                    if (dwell_q != '0) begin
                        state_d = ST_DWELL_HI;
                        timer_d = dwell_q;
                    end else begin
                        state_d = ST_RAMP_DN;
                    end
                end
            end
            ST_DWELL_HI: begin
                ena     = 1'b1;
                hold    = 1'b1;
                timer_d = timer_q - 1'b1;
                if (timer_q == DWELL_W'(1)) state_d = ST_RAMP_DN;
            end
            ST_RAMP_DN: begin
                ena  = 1'b1;
                hold = at_lo;
                if (at_lo) begin
                    if (dwell_q != '0) begin
                        state_d = ST_DWELL_LO;
                        timer_d = dwell_q;
                    end else begin
                        end_rep = 1'b1;
                    end
                end
            end
            ST_DWELL_LO: begin
                ena     = 1'b1;
                hold    = 1'b1;
                timer_d = timer_q - 1'b1;
                if (timer_q == DWELL_W'(1)) end_rep = 1'b1;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (end_rep) begin
            rep_d   = rep_next;
            state_d = (rep_next == reps_q) ? ST_DONE : ST_RAMP_UP;
        end

        // Abort freezes the repetition count so software can see how far it got.
        if (abort && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            rep_d   = rep_q;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            rep_q   <= '0;
            err_q   <= 1'b0;
            lo_q    <= '0;
            hi_q    <= '0;
            dwell_q <= '0;
            reps_q  <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            rep_q   <= rep_d;
            err_q   <= err_d;
            if (load_cfg) begin
                lo_q    <= cfg_lo;
                hi_q    <= cfg_hi;
                dwell_q <= cfg_dwell;
                reps_q  <= cfg_reps;
            end
        end
    end

    updn_counter #(.W(CNT_W)) u_cnt (
        .clk     (clk),
        .rstn    (rstn),
        .ena     (ena),
        .up_down (up_down),
        .hold    (hold),
        .cnt     (cnt)
    );

    assign busy    = (state_q != ST_IDLE);
    assign phase   = state_q;
    assign rep_idx = rep_q;
    assign done    = (state_q == ST_DONE);
    assign cfg_err = err_q;

endmodule

// File: tb/tb_sweep_ctrl.sv
// tb/tb_sweep_ctrl.sv - scoreboard bench for sweep_ctrl
module tb_sweep_ctrl;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] cfg_lo = '0;
    logic [7:0] cfg_hi = '0;
    logic [7:0] cfg_dwell = '0;
    logic [3:0] cfg_reps = '0;
    logic [7:0] cnt;
    logic       busy;
    logic [2:0] phase;
    logic [3:0] rep_idx;
    logic       done;
    logic       cfg_err;

    int checks = 0;
    int failures = 0;

    // {cnt, busy, done, cfg_err, rep_idx}
    typedef logic [14:0] obs_t;
    obs_t sb_q[$];

    always #5 clk = ~clk;

    sweep_ctrl dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .abort     (abort),
        .cfg_lo    (cfg_lo),
        .cfg_hi    (cfg_hi),
        .cfg_dwell (cfg_dwell),
        .cfg_reps  (cfg_reps),
        .cnt       (cnt),
        .busy      (busy),
        .phase     (phase),
        .rep_idx   (rep_idx),
        .done      (done),
        .cfg_err   (cfg_err)
    );

    function automatic obs_t mk(input logic [7:0] c, input logic b, input logic d,
                                input logic e, input logic [3:0] r);
        return {c, b, d, e, r};
    endfunction

    function automatic obs_t cur();
        return {cnt, busy, done, cfg_err, rep_idx};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic kick(input logic [7:0] lo, input logic [7:0] hi,
                        input logic [7:0] dw, input logic [3:0] reps);
        cfg_lo    = lo;
        cfg_hi    = hi;
        cfg_dwell = dw;
        cfg_reps  = reps;
        start     = 1'b1;
        step();
        start     = 1'b0;
    endtask

    task automatic test_reset();
        start = 1'b1;
        #12;
        checks++;
        if ({cnt, busy, phase, rep_idx, done, cfg_err} !== 17'd0) begin
            failures++;
            $display("FAIL reset got cnt=%0d busy=%b phase=%0d rep=%0d done=%b err=%b exp all 0",
                     cnt, busy, phase, rep_idx, done, cfg_err);
        end
        start = 1'b0;
        rstn  = 1'b1;
        step();
    endtask

    task automatic test_basic_profile();
        int   c_exp[14];
        obs_t e, o;
        c_exp = '{0, 1, 2, 3, 4, 5, 5, 5, 4, 3, 2, 2, 2, 0};
        for (int i = 0; i < 14; i++)
            sb_q.push_back(mk(8'(c_exp[i]), (i + 1) <= 13, (i + 1) == 13, 1'b0, 4'((i + 1) >= 13)));
        kick(8'd2, 8'd5, 8'd1, 4'd1);
        for (int i = 0; i < 14; i++) begin
            e = sb_q.pop_front();
            o = cur();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL basic cyc=%0d got cnt=%0d busy=%b done=%b err=%b rep=%0d exp cnt=%0d busy=%b done=%b err=%b rep=%0d",
                         i + 1, o[14:7], o[6], o[5], o[4], o[3:0], e[14:7], e[6], e[5], e[4], e[3:0]);
            end
            step();
        end
    endtask

    task automatic test_zero_limits();
        int   r_exp[8];
        obs_t e, o;
        r_exp = '{0, 0, 1, 1, 2, 2, 3, 3};
        for (int i = 0; i < 8; i++)
            sb_q.push_back(mk(8'd0, (i + 1) <= 7, (i + 1) == 7, 1'b0, 4'(r_exp[i])));
        kick(8'd0, 8'd0, 8'd0, 4'd3);
        for (int i = 0; i < 8; i++) begin
            e = sb_q.pop_front();
            o = cur();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL zero_limits cyc=%0d got cnt=%0d busy=%b done=%b rep=%0d exp cnt=%0d busy=%b done=%b rep=%0d",
                         i + 1, o[14:7], o[6], o[5], o[3:0], e[14:7], e[6], e[5], e[3:0]);
            end
            step();
        end
    endtask

    task automatic test_cfg_err();
        kick(8'd7, 8'd3, 8'd0, 4'd1);
        checks++;
        if ({cfg_err, busy, phase} !== 5'b1_0_000) begin
            failures++;
            $display("FAIL lo_gt_hi got err=%b busy=%b phase=%0d exp err=1 busy=0 phase=0", cfg_err, busy, phase);
        end
        step();
        checks++;
        if ({cfg_err, busy} !== 2'b00) begin
            failures++;
            $display("FAIL lo_gt_hi_after got err=%b busy=%b exp 0 0", cfg_err, busy);
        end
        kick(8'd0, 8'd5, 8'd0, 4'd0);
        checks++;
        if ({cfg_err, busy, phase} !== 5'b1_0_000) begin
            failures++;
            $display("FAIL reps_zero got err=%b busy=%b phase=%0d exp err=1 busy=0 phase=0", cfg_err, busy, phase);
        end
        step();
        checks++;
        if ({cfg_err, phase, cnt} !== 12'd0) begin
            failures++;
            $display("FAIL reps_zero_after got err=%b phase=%0d cnt=%0d exp 0 0 0", cfg_err, phase, cnt);
        end
        abort = 1'b1;
        kick(8'd7, 8'd3, 8'd0, 4'd1);
        abort = 1'b0;
        checks++;
        if ({cfg_err, busy, phase} !== 5'd0) begin
            failures++;
            $display("FAIL start_abort_idle got err=%b busy=%b phase=%0d exp 0 0 0", cfg_err, busy, phase);
        end
        step();
    endtask

    task automatic test_abort();
        int n = 0;
        bit seen_done = 1'b0;
        kick(8'd1, 8'd200, 8'd0, 4'd2);
        while (!(cnt == 8'd100 && rep_idx == 4'd1 && phase == 3'd1) && n < 1000) begin
            if (done) seen_done = 1'b1;
            step();
            n++;
        end
        checks++;
        if (n >= 1000) begin
            failures++;
            $display("FAIL abort_wait got timeout cnt=%0d rep=%0d exp cnt=100 rep=1 on up-ramp", cnt, rep_idx);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        checks++;
        if ({phase, busy, rep_idx, done} !== {3'd0, 1'b0, 4'd1, 1'b0}) begin
            failures++;
            $display("FAIL abort_idle got phase=%0d busy=%b rep=%0d done=%b exp 0 0 1 0", phase, busy, rep_idx, done);
        end
        step();
        checks++;
        if ({cnt, rep_idx, done} !== {8'd0, 4'd1, 1'b0} || seen_done) begin
            failures++;
            $display("FAIL abort_clear got cnt=%0d rep=%0d done=%b seen_done=%b exp 0 1 0 0",
                     cnt, rep_idx, done, seen_done);
        end
    endtask

    task automatic test_start_while_busy();
        int   c_exp[14];
        obs_t e, o;
        c_exp = '{0, 1, 2, 3, 4, 5, 5, 5, 4, 3, 2, 2, 2, 0};
        for (int i = 0; i < 14; i++)
            sb_q.push_back(mk(8'(c_exp[i]), (i + 1) <= 13, (i + 1) == 13, 1'b0, 4'((i + 1) >= 13)));
        kick(8'd2, 8'd5, 8'd1, 4'd1);
        for (int i = 0; i < 14; i++) begin
            e = sb_q.pop_front();
            o = cur();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL busy_start cyc=%0d got cnt=%0d busy=%b done=%b err=%b rep=%0d exp cnt=%0d busy=%b done=%b err=%b rep=%0d",
                         i + 1, o[14:7], o[6], o[5], o[4], o[3:0], e[14:7], e[6], e[5], e[4], e[3:0]);
            end
            start = (i == 3 || i == 9);
            cfg_lo = 8'd0; cfg_hi = 8'd9; cfg_dwell = 8'd0; cfg_reps = 4'd3;
            step();
        end
        start = 1'b0;
    endtask

    task automatic test_async_reset();
        int n = 0;
        kick(8'd2, 8'd5, 8'd3, 4'd1);
        while (phase != 3'd2 && n < 50) begin
            step();
            n++;
        end
        checks++;
        if (n >= 50 || cnt !== 8'd5) begin
            failures++;
            $display("FAIL dwell_wait got phase=%0d cnt=%0d exp phase=2 cnt=5", phase, cnt);
        end
        #2 rstn = 1'b0;
        #1;
        checks++;
        if ({cnt, busy, phase, rep_idx, done, cfg_err} !== 17'd0) begin
            failures++;
            $display("FAIL async_reset got cnt=%0d busy=%b phase=%0d rep=%0d done=%b err=%b exp all 0",
                     cnt, busy, phase, rep_idx, done, cfg_err);
        end
        #2 rstn = 1'b1;
        step();
    endtask

    task automatic test_after_reset();
        int   c_exp[10];
        obs_t e, o;
        c_exp = '{0, 1, 2, 3, 3, 2, 1, 0, 0, 0};
        for (int i = 0; i < 10; i++)
            sb_q.push_back(mk(8'(c_exp[i]), (i + 1) <= 9, (i + 1) == 9, 1'b0, 4'((i + 1) >= 9)));
        kick(8'd0, 8'd3, 8'd0, 4'd1);
        for (int i = 0; i < 10; i++) begin
            e = sb_q.pop_front();
            o = cur();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL after_reset cyc=%0d got cnt=%0d busy=%b done=%b rep=%0d exp cnt=%0d busy=%b done=%b rep=%0d",
                         i + 1, o[14:7], o[6], o[5], o[3:0], e[14:7], e[6], e[5], e[3:0]);
            end
            step();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic_profile();
        test_zero_limits();
        test_cfg_err();
        test_abort();
        test_start_while_busy();
        test_async_reset();
        test_after_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sweep_ctrl.md
# sweep_ctrl

Triangular sweep sequencer for the 8-bit up/down counter datapath. On a start pulse it drives the counter's `ena`, `up_down` and `hold` controls through a programmed profile. The profile ramps from 0 up to a high limit, dwells, ramps down to a low limit, dwells, and repeats for a set number of repetitions. It then reports completion and returns the counter to 0. It sits between the register/config logic and the counter, which it instantiates.

## Interface
- `CNT_W`, 8, counter and limit width
- `DWELL_W`, 8, dwell timer width
- `REP_W`, 4, repetition count width

Clock and reset: one clock; reset is asynchronous and active-low.

- `clk`  in  1  clock, all state changes on rising edge
- `rstn`  in  1  asynchronous active-low reset
- `start`  in  1  one-cycle request; sampled only in IDLE
- `abort`  in  1  stop any active sweep
- `cfg_lo`  in  CNT_W  low limit
- `cfg_hi`  in  CNT_W  high limit
- `cfg_dwell`  in  DWELL_W  extra hold cycles at each limit
- `cfg_reps`  in  REP_W  number of up/down repetitions
- `cnt`  out  CNT_W  counter value; reset 0
- `busy`  out  1  high in any state except IDLE; reset 0
- `phase`  out  3  current state encoding; reset IDLE
- `rep_idx`  out  REP_W  completed repetitions; reset 0
- `done`  out  1  one-cycle pulse on normal completion; reset 0
- `cfg_err`  out  1  one-cycle pulse when a start is rejected; reset 0

## Operation
- States: IDLE, RAMP_UP, DWELL_HI, RAMP_DN, DWELL_LO, DONE.
- Counter controls are decoded combinationally from state and `cnt`.
  - IDLE and DONE: `ena`=0. The counter clears to 0 on the next edge.
  - RAMP_UP: `ena`=1, `up_down`=1, `hold`=(cnt==hi).
  - RAMP_DN: `ena`=1, `up_down`=0, `hold`=(cnt==lo).
  - DWELL_*: `ena`=1, `hold`=1.
- Start handling:
  - In IDLE, `start`=1 with `cfg_lo`>`cfg_hi` or `cfg_reps`==0 gives `cfg_err`=1 next cycle; the block stays in IDLE.
  - Otherwise config is latched into shadow registers, `rep_idx` is cleared, and the state goes to RAMP_UP.
  - Config inputs are ignored while busy.
- RAMP_UP, when cnt==hi:
  - go to DWELL_HI if dwell>0; the dwell timer loads dwell.
  - go to RAMP_DN if dwell==0.
- DWELL_HI: decrement the timer; on the timer's last cycle go to RAMP_DN.
- RAMP_DN, when cnt==lo:
  - go to DWELL_LO if dwell>0.
  - otherwise take the end-of-repetition step directly.
- End of repetition (leaving DWELL_LO, or RAMP_DN with dwell==0):
  - `rep_idx`+1.
  - If the new `rep_idx`==reps, go to DONE; else go to RAMP_UP.
- DONE: lasts one cycle with `done`=1, then IDLE.
- `abort`=1 in any non-IDLE state: next state is IDLE.
  - No `done` pulse.
  - `rep_idx` keeps its value.
  - `cnt` clears one cycle after IDLE is entered.
- Simultaneous `start` and `abort` in IDLE: abort wins; nothing happens, no `cfg_err`.
- `start` while busy is ignored.
- Counter arithmetic is modulo 2^CNT_W. The limit compare prevents overshoot, so wrap never occurs with legal config.

## Timing
- `start` accepted at edge k: cycle k+1 is RAMP_UP with cnt=0; cnt reaches hi in cycle k+1+hi.
- Each limit value is visible on `cnt` for exactly cfg_dwell+2 consecutive cycles. hi==0 and lo==hi are legal.
- From the second repetition on, ramps run lo→hi.
- `done`, `cfg_err`, `busy` and `phase` are Moore decodes of registered state, so they are glitch-free.
- Reset mid-sweep: all outputs return to their reset values immediately (asynchronous).

## Structure
- Package `sweep_pkg`:
  - state enum `sweep_state_t`
  - default widths CNT_W/DWELL_W/REP_W
- Sub-module `updn_counter`:
  - clear when `ena`=0, hold when `hold`=1, otherwise ±1.
  - Async active-low reset to 0.
- The FSM, shadow config, dwell timer and repetition counter live in `sweep_ctrl`.

## Test plan
- lo=2, hi=5, dwell=1, reps=1, start in cycle 0:
  - cnt per cycle from 1: 0,1,2,3,4,5,5,5,4,3,2,2,2, then 0.
  - `done` in cycle 13; `busy` high cycles 1–13.
- lo=0, hi=0, dwell=0, reps=3 → cnt stays 0, `rep_idx` steps 1,2,3, one `done`, no wrap to 255.
- cfg_lo=7, cfg_hi=3, start → `cfg_err` pulse next cycle; `busy` stays 0.
- cfg_reps=0, start → `cfg_err` pulse; no state change.
- lo=1, hi=200, dwell=0, reps=2; abort when cnt=100 on the second up-ramp:
  - IDLE next cycle, `rep_idx`=1, cnt=0 one cycle later, no `done`.
- Start during a sweep (new cfg) → ignored; sweep finishes with the original limits.
- `rstn` low mid-DWELL_HI → cnt=0, busy=0, phase=IDLE asynchronously.
- After reset release, start works normally.
